result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 100 ++++++++++
 1 files changed

// File: rtl/result_collector.sv
// Serial result-bit collector: assembles datapath result bits into a word, LSB-first (Mult)
// or MSB-first (RS). Optional abort input enabled by defining RESULT_COLLECTOR_ABORT_EN.
module result_collector #(
  parameter int unsigned WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef RESULT_COLLECTOR_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic                   op,
  input  logic [7:0]             nsteps,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [WORD_LENGTH-1:0] Q,
  output logic                   busy,
  output logic                   done
);

  // nsteps is 8 bits wide, so a word wider than 255 never clamps it.
  localparam int unsigned WlClamp = (WORD_LENGTH > 255) ? 255 : WORD_LENGTH;
  localparam logic [7:0]  WlSteps = 8'(WlClamp);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] q_q, q_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             steps_q, steps_d;
  logic                   op_q, op_d;
  logic [7:0]             eff_steps;

  assign eff_steps = (nsteps > WlSteps) ? WlSteps : nsteps;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    op_d    = op_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d     = '0;
          cnt_d   = '0;
          op_d    = op;
          steps_d = eff_steps;
          state_d = (eff_steps == 8'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (bit_valid) begin
          q_d   = op_q ? {q_q[WORD_LENGTH-2:0], bit_in} : {bit_in, q_q[WORD_LENGTH-1:1]};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == steps_q - 8'd1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef RESULT_COLLECTOR_ABORT_EN
    // Abort overrides any bit accepted on the same edge.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      q_d     = '0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      steps_q <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      op_q    <= op_d;
    end
  end

  assign Q    = q_q;
  assign busy = (state_q == StCollect);
  assign done = (state_q == StDone);

endmodule
